// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the three memory-side buses that meet at mem_port_arbiter:
//     i_*  instruction-fetch port of the core (read only)
//     d_*  data port of the core (load / store with byte lanes)
//     m_*  the single-ported, registered-read RAM
//   slave  : the arbiter's view (takes core requests, drives the RAM)
//   master : the surrounding system's view (core ports plus RAM instance)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

  // instruction fetch port
  logic [31:0] i_addr;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic        i_err;

  // data port
  logic [31:0] d_addr;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic        d_err;

  // RAM side
  logic [31:0] m_a;
  logic        m_we;
  logic [31:0] m_wd;
  logic [3:0]  m_byteenable;
  logic [31:0] m_rd;

  modport slave (
    input  i_addr, i_read,
    output i_waitrequest, i_readdata, i_err,
    input  d_addr, d_read, d_write, d_writedata, d_byteenable,
    output d_waitrequest, d_readdata, d_err,
    output m_a, m_we, m_wd, m_byteenable,
    input  m_rd
  );

  modport master (
    output i_addr, i_read,
    input  i_waitrequest, i_readdata, i_err,
    output d_addr, d_read, d_write, d_writedata, d_byteenable,
    input  d_waitrequest, d_readdata, d_err,
    input  m_a, m_we, m_wd, m_byteenable,
    output m_rd
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, registered-read RAM between the core's
//   instruction-fetch port and its data port. Requests are arbitrated
//   round-robin in IDLE, then one access is sequenced at a time:
//     read          IDLE -> RD -> RD_RESP
//     full store    IDLE -> WR
//     partial store IDLE -> RMW_RD -> RMW_WR   (RAM writes whole words)
//     null store    IDLE -> DONE
//     rejected      IDLE -> ERR   (misaligned, or load+store together)
//   Every access is followed by one IDLE arbitration cycle.
//
// Ports
//   clk      rising-edge clock shared with core and RAM
//   reset_n  synchronous active-low reset; also blocks RAM writes and
//            completion strobes in any cycle where it is low
//   bus      mem_port_arbiter_if.slave (i_*, d_*, m_* buses)
// -----------------------------------------------------------------------------
module mem_port_arbiter (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD      = 3'd1;
  localparam logic [2:0] ST_RD_RESP = 3'd2;
  localparam logic [2:0] ST_RMW_RD  = 3'd3;
  localparam logic [2:0] ST_RMW_WR  = 3'd4;
  localparam logic [2:0] ST_WR      = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;
  localparam logic [2:0] ST_ERR     = 3'd7;

  // Byte-lane merge for read-modify-write: enabled lanes take the store
  // data, the others keep the word just read from the RAM.
  function automatic logic [31:0] merge_bytes(input logic [31:0] new_w,
                                              input logic [31:0] old_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return res;
  endfunction

  // Registered state
  logic [2:0]  state_r;
  logic        gnt_d_r;    // 1 = data port owns the current access
  logic        last_d_r;   // 1 = last completed access was the data port
  logic [31:0] addr_r;     // word-aligned address of the current access
  logic [31:0] wdata_r;
  logic [3:0]  be_r;

  // Arbitration / next-state signals
  logic        i_pend_s;
  logic        d_pend_s;
  logic        pick_d_s;
  logic [31:0] sel_addr_s;
  logic        bad_s;
  logic        done_s;
  logic [2:0]  state_nxt_s;

  // Output decode helpers
  logic        comp_s;
  logic        we_s;

  // Arbitration and next-state selection
  always_comb begin
    i_pend_s    = bus.i_read;
    d_pend_s    = bus.d_read | bus.d_write;
    // Data wins unless the fetch port is also pending and data went last.
    pick_d_s    = d_pend_s & (~i_pend_s | ~last_d_r);
    sel_addr_s  = pick_d_s ? bus.d_addr : bus.i_addr;
    bad_s       = (sel_addr_s[1:0] != 2'b00) |
                  (pick_d_s & bus.d_read & bus.d_write);
    done_s      = 1'b0;
    state_nxt_s = state_r;

    case (state_r)
      ST_IDLE: begin
        if (i_pend_s || d_pend_s) begin
          if (bad_s) begin
            state_nxt_s = ST_ERR;
          end else if (!pick_d_s || bus.d_read) begin
            state_nxt_s = ST_RD;
          end else if (bus.d_byteenable == 4'b1111) begin
            state_nxt_s = ST_WR;
          end else if (bus.d_byteenable == 4'b0000) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RMW_RD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD:     state_nxt_s = ST_RD_RESP;
      ST_RMW_RD: state_nxt_s = ST_RMW_WR;
      ST_RD_RESP, ST_WR, ST_RMW_WR, ST_DONE, ST_ERR: begin
        done_s      = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State, grant latch and round-robin history
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      gnt_d_r  <= 1'b0;
      last_d_r <= 1'b0;
      addr_r   <= 32'h0000_0000;
      wdata_r  <= 32'h0000_0000;
      be_r     <= 4'b0000;
    end else begin
      state_r <= state_nxt_s;
      if (state_r == ST_IDLE && (i_pend_s || d_pend_s)) begin
        gnt_d_r <= pick_d_s;
        addr_r  <= {sel_addr_s[31:2], 2'b00};
        wdata_r <= bus.d_writedata;
        be_r    <= bus.d_byteenable;
      end else begin
        gnt_d_r <= gnt_d_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
        be_r    <= be_r;
      end
      if (done_s) begin
        last_d_r <= gnt_d_r;
      end else begin
        last_d_r <= last_d_r;
      end
    end
  end

  // Port and RAM outputs, decoded from the registered state. m_rd is the
  // RAM's own registered output, so read data passes straight through in
  // RD_RESP and feeds the merge in RMW_WR. reset_n gates every write and
  // completion strobe so a reset cycle never writes or completes.
  always_comb begin
    comp_s = reset_n & ((state_r == ST_RD_RESP) | (state_r == ST_WR) |
                        (state_r == ST_RMW_WR)  | (state_r == ST_DONE) |
                        (state_r == ST_ERR));
    we_s   = 1'b0;

    bus.i_waitrequest = 1'b1;
    bus.d_waitrequest = 1'b1;
    bus.i_readdata    = 32'h0000_0000;
    bus.d_readdata    = 32'h0000_0000;
    bus.i_err         = 1'b0;
    bus.d_err         = 1'b0;
    bus.m_a           = addr_r;
    bus.m_wd          = 32'h0000_0000;
    bus.m_byteenable  = 4'b1111;

    if (comp_s) begin
      if (gnt_d_r) begin
        bus.d_waitrequest = 1'b0;
      end else begin
        bus.i_waitrequest = 1'b0;
      end
    end else begin
      bus.i_waitrequest = 1'b1;
      bus.d_waitrequest = 1'b1;
    end

    case (state_r)
      ST_RD_RESP: begin
        if (!reset_n) begin
          bus.i_readdata = 32'h0000_0000;
        end else if (gnt_d_r) begin
          bus.d_readdata = bus.m_rd;
        end else begin
          bus.i_readdata = bus.m_rd;
        end
      end
      ST_WR: begin
        we_s     = 1'b1;
        bus.m_wd = wdata_r;
      end
      ST_RMW_WR: begin
        we_s     = 1'b1;
        bus.m_wd = merge_bytes(wdata_r, bus.m_rd, be_r);
      end
      ST_ERR: begin
        if (!reset_n) begin
          bus.i_err = 1'b0;
        end else if (gnt_d_r) begin
          bus.d_err = 1'b1;
        end else begin
          bus.i_err = 1'b1;
        end
      end
      default: begin
        we_s = 1'b0;
      end
    endcase

    bus.m_we = we_s & reset_n;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  typedef struct {
    logic        is_d;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          exp_cyc;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered read, whole-word write, 256 words
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (bus.m_we) ram[bus.m_a[9:2]] <= bus.m_wd;
    bus.m_rd <= ram[bus.m_a[9:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one request, wait for its completion and report what was seen.
  task automatic do_access(input vec_t v, output int cyc, output logic [31:0] rdata,
                           output logic err, output logic we_seen, output logic [31:0] wd,
                           output logic other_low, output logic got);
    logic wr_n;
    logic oth;
    cyc = -1; rdata = 32'h0; err = 1'b0; we_seen = 1'b0; wd = 32'h0;
    other_low = 1'b0; got = 1'b0;
    @(posedge clk); #1;
    if (v.is_d) begin
      bus.d_addr = v.addr; bus.d_read = v.rd; bus.d_write = v.wr;
      bus.d_writedata = v.wdata; bus.d_byteenable = v.be;
    end else begin
      bus.i_addr = v.addr; bus.i_read = 1'b1;
    end
    for (int n = 0; n < 16 && !got; n++) begin
      @(negedge clk);
      wr_n = v.is_d ? bus.d_waitrequest : bus.i_waitrequest;
      oth  = v.is_d ? bus.i_waitrequest : bus.d_waitrequest;
      if (bus.m_we) begin
        we_seen = 1'b1;
        wd      = bus.m_wd;
      end
      if (!oth) other_low = 1'b1;
      if (!wr_n) begin
        got   = 1'b1;
        cyc   = n;
        rdata = v.is_d ? bus.d_readdata : bus.i_readdata;
        err   = v.is_d ? bus.d_err : bus.i_err;
      end
    end
    @(posedge clk); #1;
    bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int          cyc;
    logic [31:0] rdata, wd;
    logic        err, we_seen, other_low, got;
    do_access(v, cyc, rdata, err, we_seen, wd, other_low, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: no completion within 16 cycles", name);
    end else begin
      check({name, " cycle"}, cyc, v.exp_cyc);
      if (v.chk_rd) check({name, " rdata"}, rdata, v.exp_rd);
      check({name, " err"}, {31'h0, err}, {31'h0, v.exp_err});
      check({name, " we"}, {31'h0, we_seen}, {31'h0, v.exp_we});
      if (v.exp_we) check({name, " m_wd"}, wd, v.exp_wd);
      check({name, " other_wait_low"}, {31'h0, other_low}, 32'h0);
    end
  endtask

  vec_t vecs [14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc1, dc2, ic;
    vec_t rv;

    //          is_d  rd    wr    addr          wdata          be       cyc chk  exp_rd        err   we    exp_wd
    vecs[0]  = '{1'b1, 1'b0, 1'b1, BASE,         32'h3C01_1234, 4'b1111, 1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h3C01_1234};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, BASE,         32'h0,         4'b0000, 2, 1'b1, 32'h3C01_1234, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, BASE+32'h10,  32'hDEAD_BEEF, 4'b1111, 1, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, BASE+32'h10,  32'h0,         4'b0000, 2, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, BASE+32'h20,  32'h1122_3344, 4'b1111, 1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1122_3344};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, BASE+32'h20,  32'hAABB_CCDD, 4'b0101, 2, 1'b0, 32'h0,        1'b0, 1'b1, 32'h11BB_33DD};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, BASE+32'h20,  32'h0,         4'b0000, 2, 1'b1, 32'h11BB_33DD, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, BASE+32'h20,  32'hFFFF_FFFF, 4'b0000, 1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, BASE+32'h20,  32'h0,         4'b0000, 2, 1'b1, 32'h11BB_33DD, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, BASE+32'h2,   32'h0,         4'b0000, 1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, BASE+32'h30,  32'h5555_5555, 4'b1111, 1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, BASE+32'h1,   32'h0,         4'b0000, 1, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, BASE+32'h20,  32'h9900_0000, 4'b1000, 2, 1'b0, 32'h0,        1'b0, 1'b1, 32'h99BB_33DD};
    vecs[13] = '{1'b1, 1'b1, 1'b0, BASE+32'h20,  32'h0,         4'b0000, 2, 1'b1, 32'h99BB_33DD, 1'b0, 1'b0, 32'h0};

    reset_n = 1'b0;
    bus.i_addr = 32'h0; bus.i_read = 1'b0;
    bus.d_addr = 32'h0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.d_writedata = 32'h0; bus.d_byteenable = 4'b0000;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst i_waitrequest", {31'h0, bus.i_waitrequest}, 32'h1);
    check("rst d_waitrequest", {31'h0, bus.d_waitrequest}, 32'h1);
    check("rst i_err", {31'h0, bus.i_err}, 32'h0);
    check("rst d_err", {31'h0, bus.d_err}, 32'h0);
    check("rst i_readdata", bus.i_readdata, 32'h0);
    check("rst d_readdata", bus.d_readdata, 32'h0);
    check("rst m_a", bus.m_a, 32'h0);
    check("rst m_we", {31'h0, bus.m_we}, 32'h0);
    check("rst m_wd", bus.m_wd, 32'h0);
    check("rst m_byteenable", {28'h0, bus.m_byteenable}, 32'hF);

    // Tie from reset: data first (cycle 2); d_read kept high as a new
    // request, so the next tie goes to instr (cycle 5), then data (cycle 8).
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.i_addr = BASE; bus.i_read = 1'b1;
    bus.d_addr = BASE + 32'h10; bus.d_read = 1'b1;
    dc1 = -1; dc2 = -1; ic = -1;
    for (int n = 0; n < 20 && dc2 < 0; n++) begin
      @(negedge clk);
      if (!bus.d_waitrequest) begin
        if (dc1 < 0) dc1 = n;
        else dc2 = n;
      end
      if (!bus.i_waitrequest && ic < 0) ic = n;
      @(posedge clk); #1;
      if (ic == n) bus.i_read = 1'b0;
      if (dc2 == n) bus.d_read = 1'b0;
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    check("tie first data cycle", dc1, 32'd2);
    check("tie instr cycle", ic, 32'd5);
    check("tie second data cycle", dc2, 32'd8);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset asserted during RMW_WR: no write, back to IDLE, word unchanged
    @(posedge clk); #1;
    bus.d_addr = BASE + 32'h20; bus.d_write = 1'b1;
    bus.d_writedata = 32'h0000_0077; bus.d_byteenable = 4'b0001;
    @(posedge clk); #1;            // cycle 1: RMW_RD
    @(posedge clk); #1;            // cycle 2: RMW_WR
    reset_n = 1'b0;
    @(negedge clk);
    check("rmw reset m_we", {31'h0, bus.m_we}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.d_write = 1'b0;
    @(negedge clk);
    check("post reset i_waitrequest", {31'h0, bus.i_waitrequest}, 32'h1);
    check("post reset d_waitrequest", {31'h0, bus.d_waitrequest}, 32'h1);
    check("post reset m_we", {31'h0, bus.m_we}, 32'h0);
    check("post reset m_a", bus.m_a, 32'h0);
    rv = vecs[13];
    run_vec(rv, "reread after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
